// File: rtl/ncl_tx_pkg.sv
// Shared types and helpers for the clocked-to-NCL transmitter and its companion bridges.
package ncl_tx_pkg;

  localparam logic [1:0] ST_NULL_WAIT = 2'd0;
  localparam logic [1:0] ST_ACCEPT    = 2'd1;
  localparam logic [1:0] ST_DATA_WAIT = 2'd2;

  typedef enum logic [1:0] {
    NULL_WAIT = ST_NULL_WAIT,
    ACCEPT    = ST_ACCEPT,
    DATA_WAIT = ST_DATA_WAIT
  } tx_state_e;

  // Completion-acknowledge meaning as seen from the transmitter.
  localparam logic RFD = 1'b1;
  localparam logic RFN = 1'b0;

  // Single-rail bit to dual-rail pair {t, f}.
  function automatic logic [1:0] dr_encode(input logic b);
    return {b, ~b};
  endfunction

endpackage

// File: rtl/ncl_sync.sv
// Asynchronous-reset-low flop chain bringing an asynchronous NCL handshake signal into the clk domain.
module ncl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rsb,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rsb) begin
    if (!rsb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ncl_dr_tx.sv
// Valid/ready to dual-rail NCL transmitter, paced by the pipeline's synchronised ki.
// Optional stall watchdog and err port enabled by defining NCL_TX_TIMEOUT_EN.
module ncl_dr_tx
  import ncl_tx_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
`ifdef NCL_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic             clk,
  input  logic             rsb,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ki,
  output logic [WIDTH-1:0] d_t,
  output logic [WIDTH-1:0] d_f,
  output logic             busy
`ifdef NCL_TX_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  tx_state_e        state;
  logic             ki_s;
  logic             take;
  logic [WIDTH-1:0] enc_t;
  logic [WIDTH-1:0] enc_f;

  ncl_sync #(.STAGES(SYNC_STAGES)) u_ki_sync (
    .clk (clk),
    .rsb (rsb),
    .d   (ki),
    .q   (ki_s)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_enc
    assign {enc_t[i], enc_f[i]} = dr_encode(in_data[i]);
  end

  // Ready is a pure state decode so the source never sees a valid->ready loop.
  assign in_ready = (state == ACCEPT);
  assign busy     = (state != ACCEPT);
  assign take     = in_ready && in_valid;

  // Rails are only ever loaded as a whole word, so every wavefront switches on one edge.
  always_ff @(posedge clk or negedge rsb) begin
    if (!rsb) begin
      state <= NULL_WAIT;
      d_t   <= '0;
      d_f   <= '0;
    end else begin
      case (state)
        NULL_WAIT: begin
          if (ki_s == RFD) state <= ACCEPT;
        end
        ACCEPT: begin
          if (take) begin
            d_t   <= enc_t;
            d_f   <= enc_f;
            state <= DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          if (ki_s == RFN) begin
            d_t   <= '0;
            d_f   <= '0;
            state <= NULL_WAIT;
          end
        end
        default: begin
          d_t   <= '0;
          d_f   <= '0;
          state <= NULL_WAIT;
        end
      endcase
    end
  end

`ifdef NCL_TX_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic [8:0] cnt_inc;
  logic       stall;

  // A wait state that does not advance this cycle is a stall; any state change clears the count.
  assign stall   = ((state == NULL_WAIT) && (ki_s != RFD)) ||
                   ((state == DATA_WAIT) && (ki_s != RFN));
  assign cnt_inc = {1'b0, stall_cnt} + 9'd1;

  always_ff @(posedge clk or negedge rsb) begin
    if (!rsb) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (!stall) begin
        stall_cnt <= '0;
      end else if (!cnt_inc[8]) begin
        stall_cnt <= cnt_inc[7:0];
      end
      if (stall && (cnt_inc >= 9'(TIMEOUT_CYCLES))) err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ncl_dr_tx.sv
// Directed bench for ncl_dr_tx with a behavioural TH22-style NCL receiver driving ki.
module tb_ncl_dr_tx;

  logic       clk = 1'b0;
  logic       rsb;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ki;
  logic [7:0] d_t;
  logic [7:0] d_f;
  logic       busy;
`ifdef NCL_TX_TIMEOUT_EN
  logic       err;
`endif

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  bit         prev_null = 1'b1;
  logic [7:0] wf_q[$];

  always #5 clk = ~clk;

  ncl_dr_tx #(
    .WIDTH          (8),
    .SYNC_STAGES    (2)
`ifdef NCL_TX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (10)
`endif
  ) dut (
    .clk      (clk),
    .rsb      (rsb),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ki       (ki),
    .d_t      (d_t),
    .d_f      (d_f),
    .busy     (busy)
`ifdef NCL_TX_TIMEOUT_EN
    ,
    .err      (err)
`endif
  );

  // Advance to the next falling edge; while monitoring, check rail legality and log each new DATA wavefront.
  task automatic tick();
    @(negedge clk);
    if (mon_en) begin
      n_cmp++;
      if (((d_t & d_f) != 8'h00) || (((d_t | d_f) != 8'h00) && ((d_t ^ d_f) != 8'hFF))) begin
        n_bad++;
        $display("FAIL rails_invariant: d_t=%h d_f=%h, required NULL or complementary DATA", d_t, d_f);
      end
      if (prev_null && ((d_t | d_f) != 8'h00)) wf_q.push_back(d_t);
      prev_null = ((d_t | d_f) == 8'h00);
    end else begin
      prev_null = 1'b1;
    end
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int k = 0;
    while (in_ready !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: in_ready=%b after %0d cycles, required 1", tag, in_ready, budget);
    end
  endtask

  task automatic wait_null(input int budget, input string tag);
    int k = 0;
    while ((d_t | d_f) !== 8'h00 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if ((d_t | d_f) !== 8'h00) begin
      n_bad++;
      $display("FAIL %s: d_t=%h d_f=%h after %0d cycles, required NULL", tag, d_t, d_f, budget);
    end
  endtask

  task automatic test_reset();
    rsb = 1'b0; ki = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    n_cmp++;
    if (d_t !== 8'h00 || d_f !== 8'h00) begin
      n_bad++; $display("FAIL reset_rails: d_t=%h d_f=%h, required 00/00", d_t, d_f);
    end
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_ctrl: in_ready=%b busy=%b, required 0/1", in_ready, busy);
    end
`ifdef NCL_TX_TIMEOUT_EN
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: err=%b, required 0", err);
    end
`endif
    rsb = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (in_ready !== 1'b0 || d_t !== 8'h00 || d_f !== 8'h00) begin
      n_bad++; $display("FAIL sync_latency: in_ready=%b d_t=%h d_f=%h, required 0/00/00", in_ready, d_t, d_f);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL accept_entry: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_single();
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (d_t !== 8'hA5 || d_f !== 8'h5A) begin
      n_bad++; $display("FAIL single_data: d_t=%h d_f=%h, required a5/5a", d_t, d_f);
    end
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL single_busy: in_ready=%b busy=%b, required 0/1", in_ready, busy);
    end
    ki = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (d_t !== 8'hA5 || d_f !== 8'h5A) begin
      n_bad++; $display("FAIL single_hold: d_t=%h d_f=%h, required a5/5a", d_t, d_f);
    end
    tick();
    n_cmp++;
    if (d_t !== 8'h00 || d_f !== 8'h00) begin
      n_bad++; $display("FAIL single_null: d_t=%h d_f=%h, required 00/00", d_t, d_f);
    end
    ki = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL single_rearm: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_stream();
    logic [7:0] words [16];
    logic [7:0] got;
    int         dly;
    words = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3,
              8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    wf_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_ready(40, "stream_ready");
      in_data = words[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (d_t !== words[i] || d_f !== ~words[i]) begin
        n_bad++; $display("FAIL stream_data[%0d]: d_t=%h d_f=%h, required %h/%h", i, d_t, d_f, words[i], ~words[i]);
      end
      dly = int'($urandom_range(1, 20));
      repeat (dly - 1) tick();
      #($urandom_range(1, 4));
      ki = 1'b0;
      wait_null(40, "stream_null");
      dly = int'($urandom_range(0, 5));
      repeat (dly) tick();
      #($urandom_range(1, 4));
      ki = 1'b1;
    end
    wait_ready(40, "stream_tail");
    mon_en = 1'b0;
    n_cmp++;
    if (wf_q.size() != 16) begin
      n_bad++; $display("FAIL stream_count: wavefronts=%0d, required 16", wf_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      got = (i < wf_q.size()) ? wf_q[i] : ~words[i];
      n_cmp++;
      if (got !== words[i]) begin
        n_bad++; $display("FAIL stream_order[%0d]: got=%h, required %h", i, got, words[i]);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    wait_ready(20, "mid_ready");
    in_data = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (d_t !== 8'hFF || d_f !== 8'h00) begin
      n_bad++; $display("FAIL mid_data: d_t=%h d_f=%h, required ff/00", d_t, d_f);
    end
    #1 rsb = 1'b0;
    #1;
    n_cmp++;
    if (d_t !== 8'h00 || d_f !== 8'h00) begin
      n_bad++; $display("FAIL mid_async_null: d_t=%h d_f=%h, required 00/00", d_t, d_f);
    end
    repeat (2) tick();
    rsb = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_null_wait: in_ready=%b busy=%b, required 0/1", in_ready, busy);
    end
    repeat (2) tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_resync: in_ready=%b, required 0", in_ready);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_rearm: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_hold_valid();
    wf_q.delete();
    mon_en = 1'b1;
    in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_data = 8'hC3;
    repeat (3) tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL hold_ready_low: in_ready=%b, required 0", in_ready);
    end
    n_cmp++;
    if (d_t !== 8'h3C || d_f !== 8'hC3) begin
      n_bad++; $display("FAIL hold_first: d_t=%h d_f=%h, required 3c/c3", d_t, d_f);
    end
    ki = 1'b0;
    wait_null(10, "hold_null");
    ki = 1'b1;
    wait_ready(10, "hold_rearm");
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (d_t !== 8'hC3 || d_f !== 8'h3C) begin
      n_bad++; $display("FAIL hold_second: d_t=%h d_f=%h, required c3/3c", d_t, d_f);
    end
    ki = 1'b0;
    wait_null(10, "hold_null2");
    ki = 1'b1;
    wait_ready(10, "hold_rearm2");
    repeat (4) tick();
    n_cmp++;
    if (d_t !== 8'h00 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL hold_idle: d_t=%h in_ready=%b, required 00/1", d_t, in_ready);
    end
    mon_en = 1'b0;
    n_cmp++;
    if (wf_q.size() != 2) begin
      n_bad++; $display("FAIL hold_count: wavefronts=%0d, required 2", wf_q.size());
    end else begin
      n_cmp++;
      if (wf_q[0] !== 8'h3C || wf_q[1] !== 8'hC3) begin
        n_bad++; $display("FAIL hold_order: got=%h,%h, required 3c,c3", wf_q[0], wf_q[1]);
      end
    end
  endtask

`ifdef NCL_TX_TIMEOUT_EN
  task automatic test_timeout();
    rsb = 1'b0; ki = 1'b1; in_valid = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL to_reset_err: err=%b, required 0", err);
    end
    rsb = 1'b1;
    wait_ready(10, "to_ready");
    in_data = 8'h96; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL to_early: err=%b after 9 stalls, required 0", err);
    end
    tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL to_set: err=%b after 10 stalls, required 1", err);
    end
    repeat (5) tick();
    n_cmp++;
    if (err !== 1'b1 || d_t !== 8'h96 || d_f !== 8'h69) begin
      n_bad++; $display("FAIL to_sticky: err=%b d_t=%h d_f=%h, required 1/96/69", err, d_t, d_f);
    end
    ki = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (d_t !== 8'h00 || d_f !== 8'h00 || err !== 1'b1) begin
      n_bad++; $display("FAIL to_null: d_t=%h d_f=%h err=%b, required 00/00/1", d_t, d_f, err);
    end
    ki = 1'b1;
    wait_ready(10, "to_rearm");
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL to_hold: err=%b, required 1", err);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rsb = 1'b0; ki = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_single();
    test_stream();
    test_reset_mid_data();
    test_hold_valid();
`ifdef NCL_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
